jam_solver: RTL and testbench

- Exhaustive job-assignment solver for an N-worker × N-job cost matrix.
- Fetches the matrix through a W/J address port, then evaluates one permutation per cycle in lexicographic order.
- Reports the minimum total cost and the number of permutations that achieve it.
- Parametrised successor of the fixed 8×8 solver. Adds a start/restart handshake, a saturating match counter, and an optional best-assignment output.

---
 rtl/jam_pkg.sv | 21 ++
 rtl/jam_solver_if.sv | 41 ++++
 rtl/jam_next_perm.sv | 42 ++++
 rtl/jam_solver.sv | 151 +++++++++++++++
 tb/tb_jam_solver.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared types and helpers for the jam_solver job-assignment search
// Optional best-assignment output is enabled by defining JAM_BEST_PERM_EN.
package jam_pkg;

  localparam int JAM_MAX_N = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } jam_state_e;

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

endpackage

// File: rtl/jam_solver_if.sv
// rtl/jam_solver_if.sv - cost-fetch port and result bus of jam_solver
// BestJob exists only when JAM_BEST_PERM_EN is defined.
interface jam_solver_if #(
  parameter int N     = 8,
  parameter int CW    = 7,
  parameter int CNT_W = 16
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + $clog2(N) + 1;

  logic             start;
  logic [IW-1:0]    W;
  logic [IW-1:0]    J;
  logic [CW-1:0]    Cost;
  logic             busy;
  logic             Valid;
  logic [SW-1:0]    MinCost;
  logic [CNT_W-1:0] MatchCount;
`ifdef JAM_BEST_PERM_EN
  logic [N*IW-1:0]  BestJob;

  modport master (
    output start, Cost,
    input  W, J, busy, Valid, MinCost, MatchCount, BestJob
  );
  modport slave (
    input  start, Cost,
    output W, J, busy, Valid, MinCost, MatchCount, BestJob
  );
`else
  modport master (
    output start, Cost,
    input  W, J, busy, Valid, MinCost, MatchCount
  );
  modport slave (
    input  start, Cost,
    output W, J, busy, Valid, MinCost, MatchCount
  );
`endif

endinterface

// File: rtl/jam_next_perm.sv
// rtl/jam_next_perm.sv - combinational lexicographic successor of an N-element permutation
// last_o flags a strictly descending input (no successor exists).
module jam_next_perm #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0][IW-1:0] perm_i,
  output logic [N-1:0][IW-1:0] perm_o,
  output logic                 last_o
);

  logic [N-1:0][IW-1:0] swp;
  int piv;
  int sw;

  always_comb begin
    piv    = 0;
    last_o = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_i[i] < perm_i[i+1]) begin
        piv    = i;
        last_o = 1'b0;
      end
    end

    // suffix right of the pivot is descending, so the rightmost larger entry is the smallest larger one
    sw = piv;
    for (int j = 0; j < N; j++) begin
      if (j > piv && perm_i[j] > perm_i[piv]) sw = j;
    end

    swp      = perm_i;
    swp[piv] = perm_i[sw];
    swp[sw]  = perm_i[piv];

    perm_o = swp;
    for (int i = 0; i < N; i++) begin
      if (i > piv) perm_o[i] = swp[N + piv - i];
    end
  end

endmodule

// File: rtl/jam_solver.sv
// rtl/jam_solver.sv - exhaustive N x N assignment solver: loads costs, scans all N! permutations
// Defining JAM_BEST_PERM_EN adds the BestJob register and output.
module jam_solver
  import jam_pkg::*;
#(
  parameter int N     = 8,
  parameter int CW    = 7,
  parameter int CNT_W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  jam_solver_if.slave  bus
);

  localparam int IW = $clog2(N);
  localparam int SW = CW + $clog2(N) + 1;
  localparam int KW = $clog2(N * N + 1);

  localparam logic [KW-1:0] K_LAST_ADDR = KW'(N * N - 1);
  localparam logic [KW-1:0] K_END       = KW'(N * N);
  localparam logic [IW-1:0] IDX_MAX     = IW'(N - 1);

  jam_state_e           state_q;
  logic [KW-1:0]        k_q;
  logic [IW-1:0]        w_q;
  logic [IW-1:0]        j_q;
  logic [IW-1:0]        pw_q;
  logic [IW-1:0]        pj_q;
  logic [CW-1:0]        cost_q [N][N];
  logic [N-1:0][IW-1:0] perm_q;
  logic [N-1:0][IW-1:0] perm_d;
  logic                 last_d;
  logic                 first_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [SW-1:0]        min_q;
  logic [SW-1:0]        sum_d;
  logic [CNT_W-1:0]     cnt_q;
`ifdef JAM_BEST_PERM_EN
  logic [N-1:0][IW-1:0] best_q;
`endif

  jam_next_perm #(
    .N  (N),
    .IW (IW)
  ) u_next_perm (
    .perm_i (perm_q),
    .perm_o (perm_d),
    .last_o (last_d)
  );

  always_comb begin
    sum_d = '0;
    for (int w = 0; w < N; w++) begin
      sum_d = sum_d + SW'(cost_q[w][perm_q[w]]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      w_q     <= '0;
      j_q     <= '0;
      pw_q    <= '0;
      pj_q    <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      min_q   <= '1;
      cnt_q   <= '0;
      for (int w = 0; w < N; w++) begin
        perm_q[w] <= IW'(w);
        for (int j = 0; j < N; j++) cost_q[w][j] <= '0;
      end
`ifdef JAM_BEST_PERM_EN
      best_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= LOAD;
            k_q     <= '0;
            w_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            first_q <= 1'b1;
            min_q   <= '1;
            cnt_q   <= '0;
          end
        end

        LOAD: begin
          // Cost arrives one cycle after its address, so write at the previous address
          pw_q <= w_q;
          pj_q <= j_q;
          if (k_q != '0) cost_q[pw_q][pj_q] <= bus.Cost;
          if (k_q < K_LAST_ADDR) begin
            if (j_q == IDX_MAX) begin
              j_q <= '0;
              w_q <= w_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
          if (k_q == K_END) begin
            state_q <= CALC;
            first_q <= 1'b1;
            for (int w = 0; w < N; w++) perm_q[w] <= IW'(w);
          end else begin
            k_q <= k_q + 1'b1;
          end
        end

        CALC: begin
          if (first_q || sum_d < min_q) begin
            min_q   <= sum_d;
            cnt_q   <= CNT_W'(1);
            first_q <= 1'b0;
`ifdef JAM_BEST_PERM_EN
            best_q  <= perm_q;
`endif
          end else if (sum_d == min_q && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
          perm_q <= perm_d;
          if (last_d) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.W          = w_q;
  assign bus.J          = j_q;
  assign bus.busy       = busy_q;
  assign bus.Valid      = valid_q;
  assign bus.MinCost    = min_q;
  assign bus.MatchCount = cnt_q;
`ifdef JAM_BEST_PERM_EN
  assign bus.BestJob    = best_q;
`endif

endmodule

// File: tb/tb_jam_solver.sv
// tb/tb_jam_solver.sv - randomized bench for jam_solver at N=3, N=4 (narrow counter) and N=8
// Results are compared with a brute-force enumeration over all N^N digit strings.
module tb_jam_solver;
  import jam_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  jam_solver_if #(.N(3), .CW(7), .CNT_W(16)) if_a ();
  jam_solver_if #(.N(4), .CW(7), .CNT_W(3))  if_b ();
  jam_solver_if #(.N(8), .CW(7), .CNT_W(16)) if_c ();

  jam_solver #(.N(3), .CW(7), .CNT_W(16)) u_a (.CLK(CLK), .RST(RST), .bus(if_a));
  jam_solver #(.N(4), .CW(7), .CNT_W(3))  u_b (.CLK(CLK), .RST(RST), .bus(if_b));
  jam_solver #(.N(8), .CW(7), .CNT_W(16)) u_c (.CLK(CLK), .RST(RST), .bus(if_c));

  int mem [3][8][8];
  int wa, ja, wb, jb, wc, jc;

  // Cost memory with one cycle of read latency
  always @(negedge CLK) begin
    wa = int'(if_a.W); ja = int'(if_a.J);
    wb = int'(if_b.W); jb = int'(if_b.J);
    wc = int'(if_c.W); jc = int'(if_c.J);
  end

  always @(posedge CLK) begin
    #1;
    if_a.Cost = 7'(mem[0][wa][ja]);
    if_b.Cost = 7'(mem[1][wb][jb]);
    if_c.Cost = 7'(mem[2][wc][jc]);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int n_of(input int which);
    return (which == 0) ? 3 : (which == 1) ? 4 : 8;
  endfunction
  function automatic int iw_of(input int which);
    return (which == 2) ? 3 : 2;
  endfunction
  function automatic int cntw_of(input int which);
    return (which == 1) ? 3 : 16;
  endfunction
  function automatic int sw_of(input int which);
    return (which == 2) ? 11 : 10;
  endfunction

  function automatic longint dut_valid(input int which);
    return (which == 0) ? longint'(if_a.Valid) : (which == 1) ? longint'(if_b.Valid) : longint'(if_c.Valid);
  endfunction
  function automatic longint dut_busy(input int which);
    return (which == 0) ? longint'(if_a.busy) : (which == 1) ? longint'(if_b.busy) : longint'(if_c.busy);
  endfunction
  function automatic longint dut_min(input int which);
    return (which == 0) ? longint'(if_a.MinCost) : (which == 1) ? longint'(if_b.MinCost) : longint'(if_c.MinCost);
  endfunction
  function automatic longint dut_cnt(input int which);
    return (which == 0) ? longint'(if_a.MatchCount) : (which == 1) ? longint'(if_b.MatchCount) : longint'(if_c.MatchCount);
  endfunction
`ifdef JAM_BEST_PERM_EN
  function automatic longint dut_best(input int which);
    return (which == 0) ? longint'(if_a.BestJob) : (which == 1) ? longint'(if_b.BestJob) : longint'(if_c.BestJob);
  endfunction
`endif

  task automatic set_start(input int which, input logic v);
    case (which)
      0: if_a.start = v;
      1: if_b.start = v;
      default: if_c.start = v;
    endcase
  endtask

  // Every base-n digit string in increasing order; non-permutations are skipped, so the
  // first minimum met is the lexicographically first minimal assignment.
  task automatic ref_model(input int which, output longint mc, output longint cnt, output longint best);
    int n, total, code, sum;
    int d [8];
    bit ok;
    bit [7:0] used;
    n = n_of(which);
    total = 1;
    for (int i = 0; i < n; i++) total = total * n;
    mc = -1; cnt = 0; best = 0;
    for (code = 0; code < total; code++) begin
      int tmp;
      tmp = code;
      for (int w = n - 1; w >= 0; w--) begin
        d[w] = tmp % n;
        tmp  = tmp / n;
      end
      used = '0; ok = 1'b1;
      for (int w = 0; w < n; w++) begin
        if (used[d[w]]) ok = 1'b0;
        used[d[w]] = 1'b1;
      end
      if (ok) begin
        sum = 0;
        for (int w = 0; w < n; w++) sum += mem[which][w][d[w]];
        if (mc < 0 || sum < mc) begin
          mc = sum; cnt = 1; best = 0;
          for (int w = 0; w < n; w++) best += longint'(d[w]) << (w * iw_of(which));
        end else if (sum == mc) begin
          cnt++;
        end
      end
    end
  endtask

  task automatic check_result(input int which, input string tag);
    longint mc, cnt, best, maxc;
    ref_model(which, mc, cnt, best);
    maxc = (longint'(1) << cntw_of(which)) - 1;
    if (cnt > maxc) cnt = maxc;
    chk({tag, "_min"}, dut_min(which), mc);
    chk({tag, "_cnt"}, dut_cnt(which), cnt);
`ifdef JAM_BEST_PERM_EN
    chk({tag, "_best"}, dut_best(which), best);
`endif
  endtask

  // Pulse start, check the cleared state, then wait for Valid and check the latency.
  // A nonzero disturb_at re-pulses start in that cycle after the start cycle.
  task automatic go(input int which, input string tag, input int disturb_at);
    int n, lat, lim;
    lat = n_of(which) * n_of(which) + 1 + fact(n_of(which)) + 1;
    lim = lat + 20;
    @(posedge CLK); #1; set_start(which, 1'b1);
    @(posedge CLK); #1; set_start(which, 1'b0);
    chk({tag, "_busy"},  dut_busy(which), 1);
    chk({tag, "_vclr"},  dut_valid(which), 0);
    chk({tag, "_cclr"},  dut_cnt(which), 0);
    chk({tag, "_mclr"},  dut_min(which), (longint'(1) << sw_of(which)) - 1);
    n = 1;
    while (dut_valid(which) == 0 && n < lim) begin
      @(posedge CLK); #1;
      n++;
      if (disturb_at != 0) set_start(which, n == disturb_at);
    end
    set_start(which, 1'b0);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_idle"}, dut_busy(which), 0);
  endtask

  task automatic fill(input int which, input int lo, input int hi);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        mem[which][w][j] = int'($urandom_range(hi, lo));
  endtask

  task automatic load_spec3();
    int rows [3][3] = '{'{5, 1, 9}, '{2, 8, 7}, '{6, 4, 3}};
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++) mem[0][w][j] = rows[w][j];
  endtask

  task automatic spec3_consts(input string tag);
    chk({tag, "_min6"}, dut_min(0), 6);
    chk({tag, "_cnt1"}, dut_cnt(0), 1);
`ifdef JAM_BEST_PERM_EN
    chk({tag, "_best102"}, dut_best(0), 33);
`endif
  endtask

  initial begin
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_w",     longint'(if_c.W), 0);
    chk("rst_j",     longint'(if_c.J), 0);
    chk("rst_busy",  dut_busy(0), 0);
    chk("rst_valid", dut_valid(0), 0);
    chk("rst_min",   dut_min(2), 2047);
    chk("rst_cnt",   dut_cnt(1), 0);
    RST = 1'b0;

    // Reset in the middle of CALC, then a clean rerun of the same matrix
    load_spec3();
    @(posedge CLK); #1; if_a.start = 1'b1;
    @(posedge CLK); #1; if_a.start = 1'b0;
    repeat (13) @(posedge CLK);
    #1;
    chk("calc_busy", dut_busy(0), 1);
    RST = 1'b1;
    #2;
    chk("abort_busy",  dut_busy(0), 0);
    chk("abort_valid", dut_valid(0), 0);
    chk("abort_min",   dut_min(0), 1023);
    chk("abort_cnt",   dut_cnt(0), 0);
`ifdef JAM_BEST_PERM_EN
    chk("abort_best",  dut_best(0), 0);
`endif
    @(posedge CLK); #1;
    RST = 1'b0;

    go(0, "spec3", 0);
    spec3_consts("spec3");
    check_result(0, "spec3_ref");

    fork
      begin
        for (int w = 0; w < 8; w++)
          for (int j = 0; j < 8; j++) mem[2][w][j] = (w == j) ? 0 : 10;
        go(2, "n8_diag", 0);
        chk("n8_diag_min", dut_min(2), 0);
        chk("n8_diag_cnt", dut_cnt(2), 1);
`ifdef JAM_BEST_PERM_EN
        chk("n8_diag_best", dut_best(2), 64'hFAC688);
`endif
      end
      begin
        go(0, "ld_disturb", 4);
        spec3_consts("ld_disturb");
        go(0, "done_restart", 0);
        spec3_consts("done_restart");

        for (int w = 0; w < 8; w++)
          for (int j = 0; j < 8; j++) begin
            mem[0][w][j] = 127;
            mem[1][w][j] = 127;
          end
        go(0, "a_all127", 0);
        chk("a_all127_min", dut_min(0), 381);
        chk("a_all127_cnt", dut_cnt(0), 6);
        go(1, "b_all127", 0);
        chk("b_all127_min", dut_min(1), 508);
        chk("b_all127_cnt", dut_cnt(1), 7);
`ifdef JAM_BEST_PERM_EN
        chk("b_all127_best", dut_best(1), 228);
`endif
        for (int w = 0; w < 8; w++)
          for (int j = 0; j < 8; j++) mem[1][w][j] = 0;
        go(1, "b_zero", 0);
        chk("b_zero_min", dut_min(1), 0);
        chk("b_zero_cnt", dut_cnt(1), 7);

        for (int t = 0; t < 8; t++) begin
          fill(0, 0, (t < 4) ? 3 : 127);
          go(0, "rnd_a", 0);
          check_result(0, "rnd_a");
          fill(1, 0, (t < 4) ? 2 : 127);
          go(1, "rnd_b", 0);
          check_result(1, "rnd_b");
        end
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
